mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage controller sitting directly upstream of the byte-addressed single-port data RAM (async read, 4-lane word write at addr..addr+3).
- Accepts load/store requests from the pipeline with byte/half/word width.
- Word-aligns the RAM address and performs read-modify-write for sub-word stores.
- Sign/zero-extends load results and flags misaligned or illegal accesses.

Parameters:
- DATA_WIDTH, 8, lane width in bits; word W = 4*DATA_WIDTH.
- ADDR_WIDTH, 12, byte address width, matching the RAM.

Ports:
- i_clk, in, 1, clock.
- i_reset_n, in, 1, asynchronous active-low reset.
- i_valid, in, 1, request present; request fields are held stable until accepted.
- o_ready, out, 1, high only in IDLE; a request is accepted on (i_valid & o_ready & (i_mem_read | i_mem_write)).
- i_mem_read, in, 1, load request.
- i_mem_write, in, 1, store request.
- i_width, in, 2, access width: 00 = byte, 01 = half, 11 = word, 10 = illegal.
- i_unsigned, in, 1, zero-extend loads (1) or sign-extend loads (0).
- i_addr, in, ADDR_WIDTH, byte address.
- i_wdata, in, W, store data, right-justified.
- o_rdata, out, W, extended load result; held until the next load completes.
- o_done, out, 1, one-cycle completion pulse.
- o_err, out, 1, valid with o_done; access was misaligned or illegal.
- o_ram_we, out, 1, RAM write enable.
- o_ram_addr, out, ADDR_WIDTH, word-aligned RAM address: latched addr with bits [1:0] forced to 00.
- o_ram_wdata, out, W, RAM write word.
- i_ram_rdata, in, W, RAM async read word at o_ram_addr.

Behaviour:
- Reset (asynchronous, immediate on i_reset_n low):
  - state = IDLE.
  - o_rdata = 0, o_done = 0, o_err = 0, o_ram_we = 0, o_ram_addr = 0, o_ram_wdata = 0.
  - Any in-flight access is abandoned; no partial RAM write occurs after reset assertion.
- o_ram_we, o_done and o_err are Moore decodes of state, so they drop together with reset.
- On acceptance, latch addr, wdata, width, unsigned and op.
- Store priority: if i_mem_read and i_mem_write are both high, the request is treated as a store.
- i_valid with neither op bit set is not accepted and has no effect.
- Errors, checked at acceptance:
  - width 10.
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 00.
  - On error: go directly to DONE with o_err = 1; no RAM write; o_rdata unchanged.
- States:
  - IDLE:
    - o_ready = 1.
    - Accept -> ACCESS, or -> DONE on error.
  - ACCESS:
    - o_ram_addr is driven from the latched aligned address; lane index L = addr[1:0].
    - Load: o_rdata <= extend(selected bytes of i_ram_rdata) -> DONE.
      - Byte: lane L, extended from bit DATA_WIDTH-1.
      - Half: lanes L+1:L, extended from bit 2*DATA_WIDTH-1.
      - Word: whole word.
    - Word store: o_ram_we = 1, o_ram_wdata = latched wdata -> DONE.
    - Sub-word store: merge register <= i_ram_rdata with lane L (byte) or lanes L+1:L (half) replaced by the low bytes of wdata -> WRITE.
  - WRITE:
    - o_ram_we = 1, o_ram_wdata = merge register -> DONE.
  - DONE:
    - o_done = 1; o_err as decided at acceptance -> IDLE.
- Latency, counted from the accept edge to the o_done cycle:
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
  - Back-to-back requests: the next accept occurs one cycle after the o_done cycle.
- Aligned addressing guarantees the RAM's addr+3 never crosses the top of memory (e.g. addr 0xFFF maps to 0xFFC).
- Lanes outside the accessed width are never modified.

Test Plan:
- Reset mid-store: assert i_reset_n = 0 while in WRITE -> o_ram_we falls immediately; RAM word unchanged; after release, o_ready = 1 and all outputs = 0.
- Byte store then load: RAM[0x100..0x103] = 11 22 33 44; store byte 0xAB at 0x102 -> o_ram_we high for exactly 1 cycle with o_ram_wdata = 0x44AB2211; RAM = 11 22 AB 44; o_done 3 cycles after accept, o_err = 0.
- Sign/zero extension: RAM word 0x80F0_7F01 at 0x200:
  - lb 0x202 -> 0xFFFFFFF0; lbu 0x202 -> 0x000000F0.
  - lh 0x202 -> 0xFFFF80F0; lhu 0x200 -> 0x00007F01.
- Misalignment: lh 0x201, sw 0x102, and width 10 each -> o_done with o_err = 1 one cycle after accept; o_ram_we never asserted; o_rdata keeps its prior value.
- Top of memory: sb 0x5A at 0xFFF -> o_ram_addr = 0xFFC; only byte 0xFFF changes.
- Back-to-back: sw 0xDEADBEEF at 0x010, then lw 0x010 presented immediately with i_valid held -> second accept one cycle after the first o_done; load returns 0xDEADBEEF.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response and data-RAM bus of the MEM-stage controller.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  localparam int W = 4 * DATA_WIDTH;
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_mem_read;
  logic                  i_mem_write;
  logic [1:0]            i_width;
  logic                  i_unsigned;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [W-1:0]          i_wdata;
  logic [W-1:0]          o_rdata;
  logic                  o_done;
  logic                  o_err;
  logic                  o_ram_we;
  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic [W-1:0]          o_ram_wdata;
  logic [W-1:0]          i_ram_rdata;
  modport slave (
    input  i_valid, i_mem_read, i_mem_write, i_width, i_unsigned, i_addr, i_wdata, i_ram_rdata,
    output o_ready, o_rdata, o_done, o_err, o_ram_we, o_ram_addr, o_ram_wdata
  );
  modport master (
    output i_valid, i_mem_read, i_mem_write, i_width, i_unsigned, i_addr, i_wdata, i_ram_rdata,
    input  o_ready, o_rdata, o_done, o_err, o_ram_we, o_ram_addr, o_ram_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller with word-aligned RAM access,
// read-modify-write for sub-word stores and sign/zero-extended loads.
module mem_access_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input logic             i_clk,
  input logic             i_reset_n,
  mem_access_unit_if.slave bus
);
  localparam int W = 4 * DATA_WIDTH;
  localparam int DW = DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;
  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [W-1:0]          wdata_q, merge_q, rdata_q, sh, ext, mask, merged;
  logic [1:0]            width_q;
  logic                  uns_q, st_q, err_q, accept, bad;
  logic [$clog2(W)-1:0]  shamt;
  assign accept = bus.i_valid & (state == IDLE) & (bus.i_mem_read | bus.i_mem_write);
  assign bad = (bus.i_width == 2'b10) | (bus.i_width == 2'b01 & bus.i_addr[0]) |
               (bus.i_width == 2'b11 & |bus.i_addr[1:0]);
  assign shamt = {addr_q[1:0], {$clog2(DW){1'b0}}};
  assign sh = bus.i_ram_rdata >> shamt;
  assign ext = width_q == 2'b11 ? sh :
               width_q == 2'b01 ? {{(2*DW){~uns_q & sh[2*DW-1]}}, sh[2*DW-1:0]} :
                                  {{(3*DW){~uns_q & sh[DW-1]}}, sh[DW-1:0]};
  assign mask = (width_q == 2'b01 ? {{(2*DW){1'b0}}, {(2*DW){1'b1}}} :
                                    {{(3*DW){1'b0}}, {DW{1'b1}}}) << shamt;
  assign merged = (bus.i_ram_rdata & ~mask) | ((wdata_q << shamt) & mask);
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      uns_q   <= 1'b0;
      st_q    <= 1'b0;
      err_q   <= 1'b0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q  <= bus.i_addr;
        wdata_q <= bus.i_wdata;
        width_q <= bus.i_width;
        uns_q   <= bus.i_unsigned;
        st_q    <= bus.i_mem_write;
        err_q   <= bad;
      end
      if (state == ACCESS && !st_q) rdata_q <= ext;
      if (state == ACCESS) merge_q <= merged;
    end
  end
  // Outputs are pure state decodes so they collapse with the async reset.
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE   ? (accept ? (bad ? DONE : ACCESS) : IDLE) :
              state == ACCESS ? ((st_q && width_q != 2'b11) ? WRITE : DONE) :
              state == WRITE  ? DONE : IDLE;
    bus.o_ready     = state == IDLE;
    bus.o_done      = state == DONE;
    bus.o_err       = (state == DONE) & err_q;
    bus.o_ram_we    = (state == WRITE) | (state == ACCESS & st_q & width_q == 2'b11);
    bus.o_ram_wdata = state == WRITE ? merge_q : wdata_q;
    bus.o_ram_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    bus.o_rdata     = rdata_q;
  end
endmodule
